// File: rtl/fifo_wr_arbiter.sv
// Round-robin merge of NUM_CH non-stallable sample streams into one FIFO write port.
// Optional macro ARB_CH_TAG_EN: the channel index replaces the MSBs of each written word.
module fifo_wr_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CH_BITS    = $clog2(NUM_CH),
  parameter int DROP_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_strobe,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [NUM_CH-1:0]            bp_keep_mask,
  input  logic                         arb_en,
  input  logic                         drop_clr,
  input  logic                         fifo_wr_full,
  input  logic                         fifo_backpressure,
  output logic                         fifo_wr_en,
  output logic [DATA_WIDTH-1:0]        fifo_wr_data,
  output logic [CH_BITS-1:0]           grant_ch,
  output logic [NUM_CH-1:0]            hold_valid,
  output logic [NUM_CH*DROP_W-1:0]     drop_cnt
);

  // FIFO write handshake: fifo_wr_en acts as valid and !fifo_wr_full as ready.
  // A word transfers on every cycle fifo_wr_en is high; it is never raised while full.

  logic [DATA_WIDTH-1:0] hold [NUM_CH];
  logic [DROP_W-1:0]     drops [NUM_CH];
  logic [CH_BITS-1:0]    last;
  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     drain;
  logic [CH_BITS-1:0]    win;
  logic                  found;
  logic                  grant;
  logic [DATA_WIDTH-1:0] sample;

  always_comb begin
    eligible = hold_valid & ch_mask & ({NUM_CH{~fifo_backpressure}} | bp_keep_mask);
    found    = 1'b0;
    win      = '0;
    // Search starts one past the last winner so every channel gets a turn.
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (int'(last) + k) % NUM_CH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = CH_BITS'(idx);
      end
    end
  end

  assign grant = arb_en & ~fifo_wr_full & found;
  assign sample = hold[win];

  always_comb begin
    drain        = '0;
    fifo_wr_en   = grant;
    fifo_wr_data = '0;
    grant_ch     = '0;
    if (grant) begin
      drain[win] = 1'b1;
      grant_ch   = win;
`ifdef ARB_CH_TAG_EN
      fifo_wr_data = {win, sample[DATA_WIDTH-CH_BITS-1:0]};
`else
      fifo_wr_data = sample;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= CH_BITS'(NUM_CH - 1);
      hold_valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold[i]  <= '0;
        drops[i] <= '0;
      end
    end else begin
      if (grant) last <= win;
      for (int i = 0; i < NUM_CH; i++) begin
        // A disabled channel loses its held sample silently.
        if (!ch_mask[i]) begin
          hold_valid[i] <= 1'b0;
        end else if (ch_strobe[i] && (!hold_valid[i] || drain[i])) begin
          hold[i]       <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
          hold_valid[i] <= 1'b1;
        end else if (drain[i]) begin
          hold_valid[i] <= 1'b0;
        end

        if (drop_clr) begin
          drops[i] <= '0;
        end else if (ch_strobe[i] && ch_mask[i] && hold_valid[i] && !drain[i]
                     && (drops[i] != {DROP_W{1'b1}})) begin
          drops[i] <= drops[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) drop_cnt[i*DROP_W +: DROP_W] = drops[i];
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected writes are queued at stimulus time and
// matched by an independent monitor on the falling edge.
module tb_fifo_wr_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CB  = 2;
  localparam int DRW = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NCH-1:0]      ch_strobe = '0;
  logic [NCH*DW-1:0]   ch_data = '0;
  logic [NCH-1:0]      ch_mask = '1;
  logic [NCH-1:0]      bp_keep_mask = '0;
  logic                arb_en = 1'b1;
  logic                drop_clr = 1'b0;
  logic                fifo_wr_full = 1'b0;
  logic                fifo_backpressure = 1'b0;
  logic                fifo_wr_en;
  logic [DW-1:0]       fifo_wr_data;
  logic [CB-1:0]       grant_ch;
  logic [NCH-1:0]      hold_valid;
  logic [NCH*DRW-1:0]  drop_cnt;

  logic [CB+DW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .CH_BITS(CB), .DROP_W(DRW)) dut (
    .clk(clk), .rst_n(rst_n), .ch_strobe(ch_strobe), .ch_data(ch_data), .ch_mask(ch_mask),
    .bp_keep_mask(bp_keep_mask), .arb_en(arb_en), .drop_clr(drop_clr),
    .fifo_wr_full(fifo_wr_full), .fifo_backpressure(fifo_backpressure),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_ch(grant_ch),
    .hold_valid(hold_valid), .drop_cnt(drop_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_strobe = '0; ch_mask = '1; bp_keep_mask = '0; arb_en = 1'b1;
    drop_clr = 1'b0; fifo_wr_full = 1'b0; fifo_backpressure = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // driver tasks
  task automatic strobe(input int ch, input logic [DW-1:0] d);
    ch_strobe[ch] = 1'b1;
    ch_data[ch*DW +: DW] = d;
  endtask

  function automatic logic [CB+DW-1:0] fmt(input int ch, input logic [DW-1:0] d);
    logic [CB-1:0] c;
    c = CB'(ch);
`ifdef ARB_CH_TAG_EN
    return {c, c, d[DW-CB-1:0]};
`else
    return {c, d};
`endif
  endfunction

  task automatic expect_wr(input int ch, input logic [DW-1:0] d);
    exp_q.push_back(fmt(ch, d));
  endtask

  function automatic logic [DRW-1:0] drop_of(input int ch);
    return drop_cnt[ch*DRW +: DRW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr_full) begin
        tests++;
        if (fifo_wr_en !== 1'b0) begin
          fails++;
          $display("FAIL wr_while_full: fifo_wr_en %0b expected 0", fifo_wr_en);
        end
      end
      if (fifo_wr_en === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: ch %0d data %0h, none expected", grant_ch, fifo_wr_data);
        end else begin
          logic [CB+DW-1:0] e;
          e = exp_q.pop_front();
          if ({grant_ch, fifo_wr_data} !== e) begin
            fails++;
            $display("FAIL write_match: ch %0d data %0h expected ch %0d data %0h",
                     grant_ch, fifo_wr_data, e[CB+DW-1:DW], e[DW-1:0]);
          end
        end
      end else if (fifo_wr_en === 1'b0) begin
        tests++;
        if (grant_ch !== '0 || fifo_wr_data !== '0) begin
          fails++;
          $display("FAIL idle_zero: ch %0d data %0h expected 0 0", grant_ch, fifo_wr_data);
        end
      end
    end
  end

  initial begin
    do_reset();
    chk("reset_hold_valid", 32'(hold_valid), 0);
    chk("reset_drop_cnt", drop_cnt[31:0] | drop_cnt[63:32], 0);
    chk("reset_wr_en", 32'(fifo_wr_en), 0);
    chk("reset_grant_ch", 32'(grant_ch), 0);
    chk("reset_wr_data", 32'(fifo_wr_data), 0);

    // single sample on ch2
    strobe(2, 16'h1234); expect_wr(2, 16'h1234);
    tick(); ch_strobe = '0;
    chk("t1_wr_en", 32'(fifo_wr_en), 1);
    chk("t1_grant_ch", 32'(grant_ch), 2);
    chk("t1_hold_valid", 32'(hold_valid[2]), 1);
    tick();
    chk("t1_hold_cleared", 32'(hold_valid), 0);

    // four-way burst from reset, then a second burst
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      strobe(i, 16'hA000 + 16'(i)); expect_wr(i, 16'hA000 + 16'(i));
    end
    tick(); ch_strobe = '0;
    repeat (5) tick();
    chk("burst1_done", 32'(hold_valid), 0);
    for (int i = 0; i < NCH; i++) begin
      strobe(i, 16'hB000 + 16'(i)); expect_wr(i, 16'hB000 + 16'(i));
    end
    tick(); ch_strobe = '0;
    repeat (5) tick();

    // full for 5 cycles while ch1 is held
    fifo_wr_full = 1'b1;
    strobe(1, 16'h0C01); tick(); ch_strobe = '0;
    tick();
    strobe(1, 16'h0C02); tick();
    strobe(1, 16'h0C03); tick(); ch_strobe = '0;
    tick();
    chk("full_drop_cnt1", 32'(drop_of(1)), 2);
    chk("full_hold1", 32'(hold_valid[1]), 1);
    expect_wr(1, 16'h0C01);
    fifo_wr_full = 1'b0;
    tick(); tick();

    // backpressure with only ch0 kept
    fifo_backpressure = 1'b1; bp_keep_mask = 4'b0001;
    strobe(0, 16'h0D00); strobe(3, 16'h0D03); expect_wr(0, 16'h0D00);
    tick(); ch_strobe = '0;
    repeat (3) tick();
    chk("bp_hold3", 32'(hold_valid[3]), 1);
    chk("bp_only_ch0", 32'(exp_q.size()), 0);
    expect_wr(3, 16'h0D03);
    fifo_backpressure = 1'b0;
    tick(); tick();

    // arb_en low blocks grants but not capture
    arb_en = 1'b0;
    strobe(2, 16'h0E02); tick(); ch_strobe = '0;
    repeat (3) tick();
    chk("arb_off_held", 32'(hold_valid[2]), 1);
    expect_wr(2, 16'h0E02);
    arb_en = 1'b1;
    tick(); tick();

    // drop counter saturation and clear-wins
    drop_clr = 1'b1; tick(); drop_clr = 1'b0;
    fifo_wr_full = 1'b1;
    strobe(0, 16'h0F00); expect_wr(0, 16'h0F00);
    tick();
    strobe(0, 16'h0F01);
    repeat (65545) tick();
    chk("drop_saturate", 32'(drop_of(0)), 32'hFFFF);
    drop_clr = 1'b1; tick();
    chk("drop_clr_wins", 32'(drop_of(0)), 0);
    drop_clr = 1'b0; ch_strobe = '0;
    fifo_wr_full = 1'b0;
    tick(); tick();

    // strobe in the same cycle its hold is granted
    strobe(1, 16'h1101); expect_wr(1, 16'h1101);
    tick();
    strobe(1, 16'h1102); expect_wr(1, 16'h1102);
    tick(); ch_strobe = '0;
    chk("drain_reload_no_drop", 32'(drop_of(1)), 0);
    tick(); tick();

    // mask clear discards a held sample; strobes while masked are ignored
    fifo_wr_full = 1'b1;
    strobe(1, 16'h1201); tick(); ch_strobe = '0;
    chk("mask_pre_held", 32'(hold_valid[1]), 1);
    ch_mask = 4'b1101; tick();
    chk("mask_discard", 32'(hold_valid[1]), 0);
    strobe(1, 16'h1202); tick(); ch_strobe = '0;
    chk("masked_strobe_ignored", 32'(hold_valid[1]), 0);
    ch_mask = '1; fifo_wr_full = 1'b0;
    repeat (3) tick();
    chk("mask_no_drop", 32'(drop_of(1)), 0);

    // mid-operation asynchronous reset
    fifo_wr_full = 1'b1;
    strobe(2, 16'h1302); tick();
    strobe(2, 16'h1303); tick(); ch_strobe = '0;
    chk("pre_reset_drop2", 32'(drop_of(2)), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_hold", 32'(hold_valid), 0);
    chk("async_reset_drop", 32'(drop_of(2)), 0);
    fifo_wr_full = 1'b0;
    tick(); rst_n = 1'b1;
    tick();

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin write arbiter that merges NUM_CH non-stallable ADC sample streams into the single write port of the acquisition FIFO.
- Each channel gets a one-entry holding register.
- The arbiter grants one held sample per cycle while the FIFO is not full, and restricts grants to a configurable priority subset while FIFO backpressure is active.
- Samples that arrive while a channel's holding register is still occupied are dropped and counted per channel.

## Interface
Parameters:
- NUM_CH, 4, number of sample channels (2..8)
- DATA_WIDTH, 16, sample and FIFO word width
- CH_BITS, $clog2(NUM_CH), channel index width
- DROP_W, 16, per-channel drop counter width

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- ch_strobe  in  NUM_CH  per-channel sample valid; no ready, single-cycle pulse per sample
- ch_data  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_mask  in  NUM_CH  1 = channel enabled
- bp_keep_mask  in  NUM_CH  channels still eligible for grant while fifo_backpressure=1
- arb_en  in  1  global grant enable
- drop_clr  in  1  synchronous clear of all drop counters
- fifo_wr_full  in  1  FIFO full flag
- fifo_backpressure  in  1  FIFO ≥90% occupancy flag
- fifo_wr_en  out  1  write strobe to FIFO
- fifo_wr_data  out  DATA_WIDTH  write word
- grant_ch  out  CH_BITS  channel being written; valid only when fifo_wr_en=1, otherwise 0
- hold_valid  out  NUM_CH  holding-register occupancy
- drop_cnt  out  NUM_CH*DROP_W  saturating drop counters, packed like ch_data

## Operation
- Reset values:
  - hold_valid=0, all drop_cnt=0, fifo_wr_en=0, fifo_wr_data=0, grant_ch=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 wins the first tie.
- Eligibility: eligible[i] = hold_valid[i] & ch_mask[i] & (!fifo_backpressure | bp_keep_mask[i]).
- Grant (combinational from registered state):
  - Grant is issued when arb_en & !fifo_wr_full & |eligible.
  - The winner is the first eligible channel searching last+1, last+2, … modulo NUM_CH.
  - On a grant: fifo_wr_en=1, fifo_wr_data=formatted hold[winner], grant_ch=winner.
  - At that clock edge, hold_valid[winner] clears and last becomes winner.
  - No grant: fifo_wr_en=0, fifo_wr_data=0, and last is unchanged.
- Capture, per channel, on ch_strobe[i] & ch_mask[i]:
  - Holding register empty, or being drained this cycle: load ch_data into hold, set hold_valid.
  - Holding register occupied and not drained: sample dropped, hold keeps the older sample, drop_cnt[i] increments, saturating at 2^DROP_W-1.
- Strobe on a masked channel: ignored, never counted.
- Clearing ch_mask[i] discards hold[i] at the next edge with no drop count.
- drop_clr=1: all counters become 0 at the next edge; clear wins over a simultaneous drop.
- arb_en=0: no grants; capture and drop counting continue normally.

## Timing
- Latency: ch_strobe in cycle t → hold_valid in cycle t+1.
  - Earliest fifo_wr_en for that sample is also cycle t+1.
- fifo_wr_en is combinational from registered state and the fifo_wr_full / fifo_backpressure inputs.
  - It must never be asserted while fifo_wr_full=1, so no word is lost at the full boundary.
- Throughput: at most one FIFO write per cycle.
  - With NUM_CH channels strobing every cycle, each channel sustains 1/NUM_CH of the cycles and drops the remainder.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Held samples are lost and not counted.

## Configuration
- Macro: ARB_CH_TAG_EN.
- Defined: fifo_wr_data = {winner[CH_BITS-1:0], sample[DATA_WIDTH-CH_BITS-1:0]}. The channel index replaces the sample MSBs.
- Undefined: fifo_wr_data = sample unmodified. The channel index is available only on grant_ch.

## Test plan
- Reset, then NUM_CH=4, all masks=1, single strobe on ch2 with data 0x1234 at cycle t:
  - fifo_wr_en=1 at t+1, grant_ch=2.
  - fifo_wr_data=0x1234, or 0x9234 with ARB_CH_TAG_EN.
  - hold_valid=0 at t+2.
- All four channels strobe in the same cycle → four consecutive writes in order 0,1,2,3. A second burst afterwards also starts at 0 (last=3).
- fifo_wr_full=1 for 5 cycles while ch1 is held:
  - No fifo_wr_en during those 5 cycles.
  - Two further ch1 strobes give drop_cnt[1]=2, and the original sample is written once full deasserts.
- fifo_backpressure=1, bp_keep_mask=4'b0001, ch0 and ch3 held → only ch0 written; ch3 written only after backpressure drops.
- ch0 strobing every cycle for 2^16+10 cycles with fifo_wr_full=1:
  - drop_cnt[0] saturates at 0xFFFF.
  - drop_clr together with a drop gives 0 on the next cycle.
- Strobe on ch1 in the same cycle its hold is granted → no drop, and the new sample is written on the following cycle. Separately, clearing ch_mask[1] while held → hold_valid[1]=0 with no write and no drop.
